// File: rtl/punc_arb_pkg.sv
// Shared definitions for the PUnC data-memory arbiter.
//   Requester identifiers (REQ_CPU, REQ_EXT) used by the round-robin pointer,
//   arbiter state codes (ST_IDLE, ST_LOCK_EXT) and the round-robin tie-break
//   helper.
package punc_arb_pkg;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_EXT = 1'b1;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_LOCK_EXT = 1'b1;

    // On a tie the requester that was not granted last wins.
    function automatic logic rr_pick(input logic last_gnt);
        return ~last_gnt;
    endfunction

endpackage

// File: rtl/punc_arb_sat_cnt.sv
// Saturating event counter used for the arbiter statistics.
//   i_clk  clock
//   i_rst  asynchronous active-high reset (clears count)
//   i_inc  count one event this cycle
//   i_clr  synchronous clear; takes priority over i_inc
//   o_cnt  current count, sticks at all-ones
module punc_arb_sat_cnt #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/punc_mem_arbiter.sv
// Arbiter sharing PUnC's single-port data memory between the CPU and an
// external requester (program loader / debug DMA). One access per cycle.
//   clk, rst                     clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata        CPU request, held stable until cpu_gnt
//   cpu_gnt, cpu_rvalid          CPU grant (combinational), read data valid
//   ext_req/we/lock/addr/wdata   external request; ext_lock keeps the port
//   ext_gnt, ext_rvalid          external grant (combinational), read valid
//   rdata                        mem_rdata passthrough, qualify with *_rvalid
//   mem_en/we/addr/wdata         memory access strobe and fields
//   mem_rdata                    memory read data, 1-cycle latency
// Optional build macro PUNC_ARB_STATS_EN adds stat_clr input and saturating
// counters stat_cpu_gnt, stat_ext_gnt, stat_conflict.
module punc_mem_arbiter
    import punc_arb_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic          ext_lock,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef PUNC_ARB_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_cpu_gnt,
    output logic [CNT_W-1:0] stat_ext_gnt,
    output logic [CNT_W-1:0] stat_conflict
`endif
);

    localparam int WCW = $clog2(MAX_WAIT + 1);

    logic           r_last_gnt;
    logic [0:0]     r_state;
    logic [WCW-1:0] r_wait_cnt;
    logic           r_cpu_rvalid;
    logic           r_ext_rvalid;

    logic w_override;
    logic w_cpu_gnt;
    logic w_ext_gnt;

    // Grants are masked during reset so nothing reaches memory while rst is high.
    always_comb begin
        w_cpu_gnt  = 1'b0;
        w_ext_gnt  = 1'b0;
        w_override = cpu_req && (r_wait_cnt == WCW'(MAX_WAIT));
        if (!rst) begin
            if (w_override) begin
                w_cpu_gnt = 1'b1;
            end else if (cpu_req && ext_req) begin
                if ((r_state == ST_LOCK_EXT) || (rr_pick(r_last_gnt) == REQ_EXT))
                    w_ext_gnt = 1'b1;
                else
                    w_cpu_gnt = 1'b1;
            end else begin
                w_cpu_gnt = cpu_req;
                w_ext_gnt = ext_req;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_gnt   <= REQ_EXT;
            r_state      <= ST_IDLE;
            r_wait_cnt   <= '0;
            r_cpu_rvalid <= 1'b0;
            r_ext_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid <= w_cpu_gnt && !cpu_we;
            r_ext_rvalid <= w_ext_gnt && !ext_we;

            if (w_cpu_gnt)
                r_last_gnt <= REQ_CPU;
            else if (w_ext_gnt)
                r_last_gnt <= REQ_EXT;

            // An ext grant decides the lock on its own; otherwise the lock
            // is dropped by an override or by ext going idle.
            if (w_override)
                r_state <= ST_IDLE;
            else if (w_ext_gnt)
                r_state <= ext_lock ? ST_LOCK_EXT : ST_IDLE;
            else if (!ext_req)
                r_state <= ST_IDLE;

            if (!cpu_req || w_cpu_gnt)
                r_wait_cnt <= '0;
            else if (r_wait_cnt != WCW'(MAX_WAIT))
                r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign cpu_gnt    = w_cpu_gnt;
    assign ext_gnt    = w_ext_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign ext_rvalid = r_ext_rvalid;
    assign rdata      = mem_rdata;

    assign mem_en    = w_cpu_gnt || w_ext_gnt;
    assign mem_we    = (w_cpu_gnt && cpu_we) || (w_ext_gnt && ext_we);
    assign mem_addr  = w_ext_gnt ? ext_addr  : (w_cpu_gnt ? cpu_addr  : '0);
    assign mem_wdata = w_ext_gnt ? ext_wdata : (w_cpu_gnt ? cpu_wdata : '0);

`ifdef PUNC_ARB_STATS_EN
    punc_arb_sat_cnt #(.W(CNT_W)) u_cnt_cpu (
        .i_clk (clk),
        .i_rst (rst),
        .i_inc (w_cpu_gnt),
        .i_clr (stat_clr),
        .o_cnt (stat_cpu_gnt)
    );

    punc_arb_sat_cnt #(.W(CNT_W)) u_cnt_ext (
        .i_clk (clk),
        .i_rst (rst),
        .i_inc (w_ext_gnt),
        .i_clr (stat_clr),
        .o_cnt (stat_ext_gnt)
    );

    punc_arb_sat_cnt #(.W(CNT_W)) u_cnt_conflict (
        .i_clk (clk),
        .i_rst (rst),
        .i_inc (cpu_req && ext_req),
        .i_clr (stat_clr),
        .o_cnt (stat_conflict)
    );
`endif

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Self-checking bench for punc_mem_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
// Stats checks are compiled in when PUNC_ARB_STATS_EN is defined.
module tb_punc_mem_arbiter;

    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        ext_req, ext_we, ext_lock, ext_gnt, ext_rvalid;
    logic [15:0] ext_addr, ext_wdata;
    logic [15:0] rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef PUNC_ARB_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_cpu_gnt, stat_ext_gnt, stat_conflict;
`endif

    always #5 clk = ~clk;

    punc_mem_arbiter #(.AW(16), .DW(16), .MAX_WAIT(MAXW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef PUNC_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_cpu_gnt(stat_cpu_gnt),
        .stat_ext_gnt(stat_ext_gnt), .stat_conflict(stat_conflict)
`endif
    );

    // Memory macro driven by the DUT's memory port.
    logic [15:0] macro_mem [0:65535];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) macro_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= macro_mem[mem_addr];
        end
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: who was served last, whether ext holds the port, how
    // long the CPU has been waiting, and a shadow of memory contents.
    logic [15:0] shadow [0:65535];
    int          m_last;      // 0 = CPU, 1 = EXT
    bit          m_locked;
    int          m_wait;
    bit          e_cpu_rv, e_ext_rv;
    logic [15:0] e_rdata;
    int          last_win;    // -1 none, 0 CPU, 1 EXT

    task automatic model_reset();
        m_last = 1; m_locked = 0; m_wait = 0;
        e_cpu_rv = 0; e_ext_rv = 0; last_win = -1;
    endtask

    // Entered at posedge+1 with inputs already driven; leaves at next posedge+1.
    task automatic run_cycle();
        int          win;
        bit          ovr;
        bit          n_cpu_rv, n_ext_rv;
        logic [15:0] n_rdata;
        #1;
        ovr = cpu_req && (m_wait == MAXW);
        if (ovr)                     win = 0;
        else if (cpu_req && ext_req) win = m_locked ? 1 : ((m_last == 1) ? 0 : 1);
        else if (cpu_req)            win = 0;
        else if (ext_req)            win = 1;
        else                         win = -1;

        chk("cpu_gnt", cpu_gnt, 32'(win == 0));
        chk("ext_gnt", ext_gnt, 32'(win == 1));
        chk("mem_en",  mem_en,  32'(win >= 0));
        if (win == 0) begin
            chk("mem_we_c", mem_we, cpu_we);
            chk("mem_addr_c", mem_addr, cpu_addr);
            if (cpu_we) chk("mem_wdata_c", mem_wdata, cpu_wdata);
        end else if (win == 1) begin
            chk("mem_we_e", mem_we, ext_we);
            chk("mem_addr_e", mem_addr, ext_addr);
            if (ext_we) chk("mem_wdata_e", mem_wdata, ext_wdata);
        end else begin
            chk("mem_we_idle", mem_we, 0);
        end
        chk("cpu_rvalid", cpu_rvalid, e_cpu_rv);
        chk("ext_rvalid", ext_rvalid, e_ext_rv);
        if (e_cpu_rv || e_ext_rv) chk("rdata", rdata, e_rdata);

        n_cpu_rv = 0; n_ext_rv = 0; n_rdata = e_rdata;
        if (win == 0) begin
            if (cpu_we) shadow[cpu_addr] = cpu_wdata;
            else begin n_cpu_rv = 1; n_rdata = shadow[cpu_addr]; end
        end else if (win == 1) begin
            if (ext_we) shadow[ext_addr] = ext_wdata;
            else begin n_ext_rv = 1; n_rdata = shadow[ext_addr]; end
        end
        if (cpu_req && win != 0) m_wait = (m_wait < MAXW) ? m_wait + 1 : m_wait;
        else                     m_wait = 0;
        if (win == 1)               m_locked = ext_lock;
        else if (ovr || !ext_req)   m_locked = 0;
        if (win >= 0) m_last = win;

        @(posedge clk);
        #1;
        e_cpu_rv = n_cpu_rv; e_ext_rv = n_ext_rv; e_rdata = n_rdata;
        last_win = win;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 0; ext_we = 0; ext_lock = 0; ext_addr = '0; ext_wdata = '0;
    endtask

    task automatic reset_dut();
        rst = 1;
        idle_inputs();
        cpu_req = 1;  // grants must stay low while in reset
        @(posedge clk);
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_ext_gnt", ext_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_rv", cpu_rvalid, 0);
        chk("rst_ext_rv", ext_rvalid, 0);
        cpu_req = 0;
        @(negedge clk);
        rst = 0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic new_cpu();
        cpu_req = 1; cpu_we = 1'($urandom % 2);
        cpu_addr = 16'($urandom_range(0, 15)); cpu_wdata = 16'($urandom);
    endtask

    task automatic new_ext();
        ext_req = 1; ext_we = 1'($urandom % 2); ext_lock = 1'($urandom % 2);
        ext_addr = 16'($urandom_range(0, 15)); ext_wdata = 16'($urandom);
    endtask

    initial begin
        bit cpu_pend, ext_pend;
        for (int a = 0; a < 65536; a++) begin
            macro_mem[a] = '0;
            shadow[a]    = '0;
        end
        mem_rdata = '0;
`ifdef PUNC_ARB_STATS_EN
        stat_clr = 0;
`endif
        model_reset();
        reset_dut();

        // Lone CPU read: same-cycle grant, data valid one cycle later.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
        #1;
        chk("t1_gnt", cpu_gnt, 1);
        chk("t1_addr", mem_addr, 16'h3000);
        run_cycle();
        cpu_req = 0;
        #1;
        chk("t1_rvalid", cpu_rvalid, 1);
        run_cycle();

        // Simultaneous requests from reset alternate starting with CPU.
        reset_dut();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0001;
        ext_req = 1; ext_we = 0; ext_lock = 0; ext_addr = 16'h0002;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_cpu_gnt", cpu_gnt, 32'(i % 2 == 0));
            chk("t2_ext_gnt", ext_gnt, 32'(i % 2 == 1));
            run_cycle();
        end
        idle_inputs();
        run_cycle();

        // Locked ext write burst holds off a pending CPU read.
        reset_dut();
        ext_req = 1; ext_we = 1; ext_lock = 1; ext_addr = 16'h4000; ext_wdata = 16'hA000;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin cpu_req = 1; cpu_we = 0; cpu_addr = 16'h4001; end
            if (i == 3) ext_lock = 0;
            #1;
            chk("t3_ext_gnt", ext_gnt, 1);
            chk("t3_mem_we", mem_we, 1);
            chk("t3_addr", mem_addr, 32'h4000 + 32'(i));
            run_cycle();
            ext_addr = ext_addr + 16'd1; ext_wdata = ext_wdata + 16'd1;
        end
        ext_req = 0;
        #1;
        chk("t3_cpu_gnt", cpu_gnt, 1);
        run_cycle();
        cpu_req = 0;
        run_cycle();

        // Endless lock: starvation limit forces the CPU through.
        reset_dut();
        ext_req = 1; ext_we = 0; ext_lock = 1; ext_addr = 16'h0005;
        run_cycle();
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0007; cpu_wdata = 16'h1234;
        for (int i = 1; i <= 9; i++) begin
            #1;
            chk("t4_cpu_gnt", cpu_gnt, 32'(i == 9));
            run_cycle();
            ext_addr = 16'($urandom_range(0, 15));
        end
        cpu_we = 0;
        for (int i = 0; i < 12; i++) run_cycle();
        idle_inputs();
        run_cycle();
        run_cycle();

        // Async reset right after a granted read drops its rvalid.
        reset_dut();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
        run_cycle();
        rst = 1;
        #1;
        chk("t5_rvalid", cpu_rvalid, 0);
        chk("t5_gnt", cpu_gnt, 0);
        @(posedge clk);
        #1;
        chk("t5_gnt_hold", cpu_gnt, 0);
        chk("t5_mem_en", mem_en, 0);
        @(negedge clk);
        cpu_req = 0;
        rst = 0;
        model_reset();
        @(posedge clk);
        #1;

`ifdef PUNC_ARB_STATS_EN
        stat_clr = 1;
        run_cycle();
        stat_clr = 0;
        for (int i = 0; i < 10; i++) begin
            if (!cpu_req) new_cpu();
            if (!ext_req) begin new_ext(); ext_lock = 0; end
            run_cycle();
            if (last_win == 0) cpu_req = 0;
            if (last_win == 1) ext_req = 0;
        end
        idle_inputs();
        #1;
        chk("t6_conflict", stat_conflict, 10);
        stat_clr = 1;
        run_cycle();
        stat_clr = 0;
        #1;
        chk("t6_conflict_clr", stat_conflict, 0);
        run_cycle();
`endif

        // Randomized traffic; requests stay stable until granted.
        reset_dut();
        cpu_pend = 0; ext_pend = 0;
        for (int c = 0; c < 800; c++) begin
            if (!cpu_pend) begin
                if ($urandom % 3 != 0) begin new_cpu(); cpu_pend = 1; end
                else cpu_req = 0;
            end
            if (!ext_pend) begin
                if ($urandom % 4 != 0) begin new_ext(); ext_pend = 1; end
                else ext_req = 0;
            end
            run_cycle();
            if (last_win == 0) cpu_pend = 0;
            if (last_win == 1) ext_pend = 0;
        end
        idle_inputs();
        run_cycle();
        run_cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
